l1_victim_writeback: RTL and testbench
======================================

# l1_victim_writeback

Eviction engine for the 4-way L1 data cache. On a miss, the cache controller hands it the victim way chosen by the L1 LRU replacement logic and the set index. The engine reads the victim line, its tag and its status bits from the data/tag arrays. If the line is valid and dirty, it writes the line back to memory as an address phase followed by a 4-beat data burst and a write response. It signals completion so the controller can start the refill and the LRU update.

## Interface
- INDEX_W, 4, set-index width (DEPTH = 2**INDEX_W sets)
- WAY_W, 2, way-select width (4 ways)
- ADDR_W, 32, byte-address width
- LINE_W, 128, cache line width in bits
- BEAT_W, 32, memory data beat width; BEATS = LINE_W/BEAT_W = 4
- TAG_W, ADDR_W-INDEX_W-4, tag width (4 offset bits for a 16-byte line)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- evict_req_i  in  1  eviction request, qualified by evict_rdy_o
- evict_rdy_o  out  1  engine idle and able to accept a request
- evict_index_i  in  INDEX_W  set index of the victim
- victim_way_i  in  WAY_W  victim way from the LRU
- arr_rd_en_o  out  1  array read strobe; data returns the next cycle
- arr_rd_index_o  out  INDEX_W  array read set index
- arr_rd_way_o  out  WAY_W  array read way
- arr_rd_data_i  in  LINE_W  line data, 1 cycle after arr_rd_en_o
- arr_rd_tag_i  in  TAG_W  line tag, same timing as the data
- arr_rd_vld_i  in  1  line valid bit, same timing as the data
- arr_rd_dirty_i  in  1  line dirty bit, same timing as the data
- mem_awvalid_o  out  1  write address valid
- mem_awready_i  in  1  write address ready
- mem_awaddr_o  out  ADDR_W  line base address {tag, index, 4'b0}
- mem_wvalid_o  out  1  write data beat valid
- mem_wready_i  in  1  write data ready
- mem_wdata_o  out  BEAT_W  data beat
- mem_wlast_o  out  1  final beat marker
- mem_bvalid_i  in  1  write response valid; the engine is always ready for it
- mem_berr_i  in  1  write response error, sampled with mem_bvalid_i
- evict_done_o  out  1  one-cycle completion pulse
- evict_wb_o  out  1  with done: 1 = a writeback was performed, 0 = the line was clean or invalid
- evict_err_o  out  1  with done: the memory response reported an error
- evict_way_o / evict_index_o  out  WAY_W / INDEX_W  latched way and index, held stable from accept through done

## Operation
- FSM states: IDLE, READ, CAPT, ADDR, DATA, RESP, DONE.
- IDLE:
  - evict_rdy_o = 1 in IDLE only.
  - A request is accepted when evict_req_i & evict_rdy_o.
  - On accept, evict_index_i and victim_way_i are latched, and the FSM moves to READ.
  - Later changes on these inputs are ignored.
- READ: arr_rd_en_o = 1 for exactly one cycle, with the latched index and way. Next state is CAPT.
- CAPT:
  - Latch arr_rd_data_i, arr_rd_tag_i, arr_rd_vld_i and arr_rd_dirty_i into the line buffer.
  - If vld & dirty, go to ADDR. Otherwise go to DONE with evict_wb_o = 0.
- ADDR: mem_awvalid_o = 1, held along with mem_awaddr_o until mem_awready_i. Then go to DATA with the beat counter at 0.
- DATA:
  - mem_wvalid_o = 1 and mem_wdata_o = line_buf[beat*BEAT_W +: BEAT_W]. Beat 0 is the least significant word.
  - The beat counter (2 bits) advances only on mem_wvalid_o & mem_wready_i.
  - mem_wlast_o = 1 while beat == BEATS-1.
  - Acceptance of the last beat moves the FSM to RESP.
  - Data is never presented before the address phase has been accepted.
- RESP: wait for mem_bvalid_i, latch mem_berr_i, then go to DONE.
  - mem_bvalid_i is sampled only in RESP. A response in any other state is a protocol violation and is ignored.
- DONE:
  - evict_done_o = 1 for one cycle, with evict_wb_o and evict_err_o valid.
  - Next state is IDLE.
  - evict_err_o = 0 on the clean path.
- There is no timeout: ADDR, DATA and RESP wait indefinitely.
- Reset mid-operation:
  - Immediately return to IDLE and clear all outputs.
  - No done pulse is produced.
  - The in-flight memory transaction is abandoned.

## Timing
- Reset values:
  - evict_rdy_o = 1.
  - All other outputs = 0: arr_rd_*, mem_*, evict_done_o, evict_wb_o, evict_err_o, evict_way_o, evict_index_o.
- All outputs are driven from registered state. There are no combinational paths from memory inputs to outputs, except the ready/valid hold behaviour implied by the state.
- With a request accepted at cycle T:
  - READ at T+1.
  - CAPT at T+2.
  - Clean path: DONE at T+3, IDLE (ready) at T+4.
- Dirty path with memory always ready:
  - ADDR at T+3.
  - DATA beats at T+4..T+7.
  - RESP at T+8, with bvalid in the same cycle.
  - DONE at T+9, IDLE at T+10.
- Each wait cycle on awready, wready or bvalid adds exactly one cycle.
- A new request can be accepted in the first cycle back in IDLE (the cycle after done). Back-to-back requests have no further bubble.

## Test plan
- Clean victim: index 5, way 2, vld=1, dirty=0.
  - Required: arr_rd_en_o at T+1 with index 5 / way 2.
  - evict_done_o at T+3 with evict_wb_o = 0.
  - mem_awvalid_o never asserted.
- Dirty writeback, zero wait: tag 0x0ABCD12, index 3, data 0x44443333_22221111_00001111_DEADBEEF, memory always ready.
  - mem_awaddr_o = {0x0ABCD12, 4'h3, 4'h0} = 0xABCD1230.
  - Beats in order: DEADBEEF, 00001111, 22221111, 44443333.
  - mem_wlast_o only on the 4th beat.
  - Done at T+9 with evict_wb_o = 1 and evict_err_o = 0.
- Backpressure:
  - Stimulus: awready low for 3 cycles; wready toggling 1/0; bvalid 5 cycles after wlast.
  - Required: awaddr, wdata and wlast held stable while their valid is high and ready is low; still exactly 4 beats; done 1 cycle after bvalid.
- Error response: dirty line, with mem_berr_i = 1 at bvalid.
  - Required: evict_done_o = 1, evict_wb_o = 1, evict_err_o = 1, then evict_rdy_o = 1 the next cycle.
- Reset mid-burst: assert rst_ni = 0 after beat 1 is accepted.
  - Required: all outputs at their reset values asynchronously and no done pulse.
  - After release, a new dirty request completes normally.
- Back-to-back and input isolation:
  - Two requests with evict_req_i held high; victim_way_i changed during the first request.
  - Required: the first request uses its latched way; the second is accepted the cycle after done.

Source files
------------

// File: rtl/l1_victim_writeback.sv
// Victim eviction engine for the 4-way L1 D-cache.
// Ports: evict_* request/done handshake, arr_rd_* array read, mem_aw*/w*/b* write burst.
module l1_victim_writeback #(
   parameter int INDEX_W = 4,
   parameter int WAY_W   = 2,
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int BEAT_W  = 32,
   parameter int TAG_W   = ADDR_W - INDEX_W - 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               evict_req_i,
   output logic               evict_rdy_o,
   input  logic [INDEX_W-1:0] evict_index_i,
   input  logic [WAY_W-1:0]   victim_way_i,
   output logic               arr_rd_en_o,
   output logic [INDEX_W-1:0] arr_rd_index_o,
   output logic [WAY_W-1:0]   arr_rd_way_o,
   input  logic [LINE_W-1:0]  arr_rd_data_i,
   input  logic [TAG_W-1:0]   arr_rd_tag_i,
   input  logic               arr_rd_vld_i,
   input  logic               arr_rd_dirty_i,
   output logic               mem_awvalid_o,
   input  logic               mem_awready_i,
   output logic [ADDR_W-1:0]  mem_awaddr_o,
   output logic               mem_wvalid_o,
   input  logic               mem_wready_i,
   output logic [BEAT_W-1:0]  mem_wdata_o,
   output logic               mem_wlast_o,
   input  logic               mem_bvalid_i,
   input  logic               mem_berr_i,
   output logic               evict_done_o,
   output logic               evict_wb_o,
   output logic               evict_err_o,
   output logic [WAY_W-1:0]   evict_way_o,
   output logic [INDEX_W-1:0] evict_index_o
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, READ, CAPT, ADDR, DATA, RESP, DONE
   } state_t;

   state_t state_q, state_d;

   logic [INDEX_W-1:0]             index_q;
   logic [WAY_W-1:0]               way_q;
   logic [TAG_W-1:0]               tag_q;
   logic [BEATS-1:0][BEAT_W-1:0]   line_q;
   logic [CNT_W-1:0]               beat_q;
   logic                           wb_q;
   logic                           err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (evict_req_i) state_d = READ;
         READ: state_d = CAPT;
         CAPT: state_d = (arr_rd_vld_i & arr_rd_dirty_i) ? ADDR : DONE;
         ADDR: if (mem_awready_i) state_d = DATA;
         DATA: if (mem_wready_i && beat_q == LAST_BEAT) state_d = RESP;
         RESP: if (mem_bvalid_i) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         index_q <= '0;
         way_q   <= '0;
         tag_q   <= '0;
         line_q  <= '0;
         beat_q  <= '0;
         wb_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && evict_req_i) begin
            index_q <= evict_index_i;
            way_q   <= victim_way_i;
         end
         if (state_q == CAPT) begin
            line_q <= arr_rd_data_i;
            tag_q  <= arr_rd_tag_i;
            wb_q   <= arr_rd_vld_i & arr_rd_dirty_i;
            err_q  <= 1'b0;
         end
         if (state_q == ADDR && mem_awready_i) beat_q <= '0;
         if (state_q == DATA && mem_wready_i) beat_q <= beat_q + 1'b1;
         // bvalid outside RESP is a protocol violation and is dropped
         if (state_q == RESP && mem_bvalid_i) err_q <= mem_berr_i;
      end
   end

   always_comb begin
      evict_rdy_o    = 1'b0;
      arr_rd_en_o    = 1'b0;
      arr_rd_index_o = '0;
      arr_rd_way_o   = '0;
      mem_awvalid_o  = 1'b0;
      mem_awaddr_o   = '0;
      mem_wvalid_o   = 1'b0;
      mem_wdata_o    = '0;
      mem_wlast_o    = 1'b0;
      evict_done_o   = 1'b0;
      evict_wb_o     = 1'b0;
      evict_err_o    = 1'b0;
      unique case (state_q)
         IDLE: evict_rdy_o = 1'b1;
         READ: begin
            arr_rd_en_o    = 1'b1;
            arr_rd_index_o = index_q;
            arr_rd_way_o   = way_q;
         end
         ADDR: begin
            mem_awvalid_o = 1'b1;
            mem_awaddr_o  = {tag_q, index_q, 4'b0000};
         end
         DATA: begin
            mem_wvalid_o = 1'b1;
            mem_wdata_o  = line_q[beat_q];
            mem_wlast_o  = (beat_q == LAST_BEAT);
         end
         DONE: begin
            evict_done_o = 1'b1;
            evict_wb_o   = wb_q;
            evict_err_o  = err_q;
         end
         default: ;
      endcase
   end

   assign evict_way_o   = way_q;
   assign evict_index_o = index_q;

endmodule

// File: tb/tb_l1_victim_writeback.sv
// Directed bench for l1_victim_writeback.
// Models the tag/data array and a configurable memory write port.
module tb_l1_victim_writeback;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         evict_req_i = 1'b0;
   logic         evict_rdy_o;
   logic [3:0]   evict_index_i = '0;
   logic [1:0]   victim_way_i = '0;
   logic         arr_rd_en_o;
   logic [3:0]   arr_rd_index_o;
   logic [1:0]   arr_rd_way_o;
   logic [127:0] arr_rd_data_i = '0;
   logic [23:0]  arr_rd_tag_i = '0;
   logic         arr_rd_vld_i = 1'b0;
   logic         arr_rd_dirty_i = 1'b0;
   logic         mem_awvalid_o;
   logic         mem_awready_i = 1'b0;
   logic [31:0]  mem_awaddr_o;
   logic         mem_wvalid_o;
   logic         mem_wready_i = 1'b0;
   logic [31:0]  mem_wdata_o;
   logic         mem_wlast_o;
   logic         mem_bvalid_i = 1'b0;
   logic         mem_berr_i = 1'b0;
   logic         evict_done_o;
   logic         evict_wb_o;
   logic         evict_err_o;
   logic [1:0]   evict_way_o;
   logic [3:0]   evict_index_o;

   l1_victim_writeback dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .evict_req_i(evict_req_i), .evict_rdy_o(evict_rdy_o),
      .evict_index_i(evict_index_i), .victim_way_i(victim_way_i),
      .arr_rd_en_o(arr_rd_en_o), .arr_rd_index_o(arr_rd_index_o),
      .arr_rd_way_o(arr_rd_way_o), .arr_rd_data_i(arr_rd_data_i),
      .arr_rd_tag_i(arr_rd_tag_i), .arr_rd_vld_i(arr_rd_vld_i),
      .arr_rd_dirty_i(arr_rd_dirty_i),
      .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i),
      .mem_awaddr_o(mem_awaddr_o),
      .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i),
      .mem_wdata_o(mem_wdata_o), .mem_wlast_o(mem_wlast_o),
      .mem_bvalid_i(mem_bvalid_i), .mem_berr_i(mem_berr_i),
      .evict_done_o(evict_done_o), .evict_wb_o(evict_wb_o),
      .evict_err_o(evict_err_o), .evict_way_o(evict_way_o),
      .evict_index_o(evict_index_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // array model contents for the next read
   logic [127:0] cfg_data;
   logic [23:0]  cfg_tag;
   logic         cfg_vld, cfg_dirty;

   always @(posedge clk_i) begin
      if (arr_rd_en_o) begin
         arr_rd_data_i  <= cfg_data;
         arr_rd_tag_i   <= cfg_tag;
         arr_rd_vld_i   <= cfg_vld;
         arr_rd_dirty_i <= cfg_dirty;
      end
   end

   // memory policy
   int   aw_stall = 0;
   logic w_toggle = 1'b0;
   int   b_delay = 0;
   logic berr_cfg = 1'b0;

   // monitor records
   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int          acc_c[$];
   int          rd_c[$];
   logic [1:0]  rd_w[$];
   logic [3:0]  rd_i[$];
   int          done_c[$];
   logic        done_wb[$];
   logic        done_err[$];
   logic [1:0]  done_way[$];
   logic [3:0]  done_idx[$];
   logic        rdy_after[$];
   logic [31:0] beats[$];
   int          aw_cnt, nbeats, w_early, b_cnt, bv_c;
   logic        aw_done, aw_pend, w_pend, b_pend, w_tog, prev_done;
   logic [31:0] aw_addr, aw_prev;
   logic [32:0] w_prev;
   logic [3:0]  last_bits;

   task automatic clear_mon();
      acc_c.delete(); rd_c.delete(); rd_w.delete(); rd_i.delete();
      done_c.delete(); done_wb.delete(); done_err.delete();
      done_way.delete(); done_idx.delete(); rdy_after.delete();
      beats.delete();
      aw_cnt = 0; nbeats = 0; w_early = 0; b_cnt = 0; bv_c = 0;
      aw_done = 0; aw_pend = 0; w_pend = 0; b_pend = 0;
      w_tog = 1; prev_done = 0; last_bits = '0;
      aw_addr = '0; aw_prev = '0; w_prev = '0;
   endtask

   initial clear_mon();

   always @(negedge clk_i) begin
      #2;
      if (prev_done) rdy_after.push_back(evict_rdy_o);
      prev_done = evict_done_o;
      if (evict_req_i && evict_rdy_o) acc_c.push_back(cyc);
      if (arr_rd_en_o) begin
         rd_c.push_back(cyc);
         rd_w.push_back(arr_rd_way_o);
         rd_i.push_back(arr_rd_index_o);
      end
      if (evict_done_o) begin
         done_c.push_back(cyc);
         done_wb.push_back(evict_wb_o);
         done_err.push_back(evict_err_o);
         done_way.push_back(evict_way_o);
         done_idx.push_back(evict_index_o);
      end
      // response channel first so it never fires with the last beat
      mem_bvalid_i = 1'b0;
      mem_berr_i   = 1'b0;
      if (b_pend) begin
         if (b_cnt == 0) begin
            mem_bvalid_i = 1'b1;
            mem_berr_i   = berr_cfg;
            bv_c   = cyc;
            b_pend = 0;
         end else b_cnt--;
      end
      if (mem_awvalid_o) begin
         aw_cnt++;
         if (aw_pend) check("aw_hold", mem_awaddr_o, aw_prev);
         if (aw_stall > 0) begin
            mem_awready_i = 1'b0;
            aw_stall--;
         end else mem_awready_i = 1'b1;
         aw_pend = !mem_awready_i;
         aw_prev = mem_awaddr_o;
         if (mem_awready_i) begin
            aw_addr = mem_awaddr_o;
            aw_done = 1;
         end
      end else begin
         mem_awready_i = 1'b0;
         aw_pend = 0;
      end
      if (mem_wvalid_o) begin
         if (!aw_done) w_early++;
         if (w_pend) check("w_hold", {mem_wlast_o, mem_wdata_o}, w_prev);
         mem_wready_i = w_toggle ? w_tog : 1'b1;
         w_tog  = !w_tog;
         w_pend = !mem_wready_i;
         w_prev = {mem_wlast_o, mem_wdata_o};
         if (mem_wready_i) begin
            beats.push_back(mem_wdata_o);
            if (nbeats < 4) last_bits[nbeats] = mem_wlast_o;
            nbeats++;
            if (mem_wlast_o) begin
               b_pend = 1;
               b_cnt  = b_delay;
            end
         end
      end else begin
         mem_wready_i = 1'b0;
         w_pend = 0;
      end
   end

   task automatic req_line(input logic [3:0] idx, input logic [1:0] way,
                           input logic vld, input logic dirty,
                           input logic [23:0] tag, input logic [127:0] data);
      cfg_vld = vld; cfg_dirty = dirty; cfg_tag = tag; cfg_data = data;
      @(negedge clk_i);
      evict_req_i = 1'b1;
      evict_index_i = idx;
      victim_way_i = way;
      @(negedge clk_i);
      evict_req_i = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk_i);
         if (done_c.size() >= n) break;
      end
      evict_req_i = 1'b0;
      if (k == 200) check("done_timeout", 0, 1);
      @(negedge clk_i);
      #3;
   endtask

   task automatic chk_reset_outs(input string tag);
      check({tag, "_rdy"}, evict_rdy_o, 1);
      check({tag, "_addr"}, mem_awaddr_o, 0);
      check({tag, "_wdata"}, mem_wdata_o, 0);
      check({tag, "_ctl"}, {arr_rd_en_o, arr_rd_index_o, arr_rd_way_o,
                            mem_awvalid_o, mem_wvalid_o, mem_wlast_o,
                            evict_done_o, evict_wb_o, evict_err_o,
                            evict_way_o, evict_index_o}, 0);
   endtask

   localparam logic [127:0] D1 =
      128'h44443333_22221111_00001111_DEADBEEF;
   localparam logic [127:0] D2 =
      128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;

   initial begin
      int n0;
      #12;
      chk_reset_outs("rst");
      @(negedge clk_i);
      rst_ni = 1'b1;

      // clean victim
      clear_mon();
      aw_stall = 0; w_toggle = 0; b_delay = 0; berr_cfg = 0;
      req_line(4'd5, 2'd2, 1, 0, 24'h111111, D2);
      wait_done(1);
      check("cl_rd_lat", rd_c[0] - acc_c[0], 1);
      check("cl_rd_idx", rd_i[0], 5);
      check("cl_rd_way", rd_w[0], 2);
      check("cl_done_lat", done_c[0] - acc_c[0], 3);
      check("cl_wb", done_wb[0], 0);
      check("cl_err", done_err[0], 0);
      check("cl_done_way", {done_way[0], done_idx[0]}, {2'd2, 4'd5});
      check("cl_no_aw", aw_cnt, 0);
      check("cl_rdy_after", rdy_after[0], 1);

      // invalid but dirty line must not be written back
      clear_mon();
      req_line(4'd7, 2'd1, 0, 1, 24'h222222, D1);
      wait_done(1);
      check("inv_wb", done_wb[0], 0);
      check("inv_no_w", aw_cnt + nbeats, 0);

      // dirty, zero wait
      clear_mon();
      req_line(4'd3, 2'd1, 1, 1, 24'hABCD12, D1);
      wait_done(1);
      check("dz_awaddr", aw_addr, 32'hABCD1230);
      check("dz_nbeats", nbeats, 4);
      check("dz_b0", beats[0], 32'hDEADBEEF);
      check("dz_b1", beats[1], 32'h00001111);
      check("dz_b2", beats[2], 32'h22221111);
      check("dz_b3", beats[3], 32'h44443333);
      check("dz_wlast", last_bits, 4'b1000);
      check("dz_done_lat", done_c[0] - acc_c[0], 9);
      check("dz_wb_err", {done_wb[0], done_err[0]}, 2'b10);
      check("dz_early", w_early, 0);

      // backpressure
      clear_mon();
      aw_stall = 3; w_toggle = 1; b_delay = 4;
      req_line(4'd9, 2'd0, 1, 1, 24'h123456, D2);
      wait_done(1);
      check("bp_awaddr", aw_addr, 32'h12345690);
      check("bp_aw_cycles", aw_cnt, 4);
      check("bp_nbeats", nbeats, 4);
      check("bp_b0", beats[0], 32'h9ABCDEF0);
      check("bp_b3", beats[3], 32'hCAFEF00D);
      check("bp_wlast", last_bits, 4'b1000);
      check("bp_done_lat", done_c[0] - acc_c[0], 19);
      check("bp_done_after_b", done_c[0] - bv_c, 1);
      check("bp_early", w_early, 0);

      // error response
      clear_mon();
      aw_stall = 0; w_toggle = 0; b_delay = 0; berr_cfg = 1;
      req_line(4'd2, 2'd3, 1, 1, 24'h0F0F0F, D1);
      wait_done(1);
      check("er_done", done_c.size(), 1);
      check("er_wb_err", {done_wb[0], done_err[0]}, 2'b11);
      check("er_rdy_after", rdy_after[0], 1);
      berr_cfg = 0;

      // reset mid-burst
      clear_mon();
      req_line(4'd4, 2'd2, 1, 1, 24'h0AAAAA, D1);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         #3;
         if (nbeats >= 2) break;
      end
      check("mr_reached", nbeats, 2);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_reset_outs("mr");
      n0 = done_c.size();
      repeat (3) @(negedge clk_i);
      check("mr_no_done", done_c.size(), n0);
      rst_ni = 1'b1;
      #3;
      clear_mon();
      req_line(4'd3, 2'd1, 1, 1, 24'hABCD12, D1);
      wait_done(1);
      check("mr_re_lat", done_c[0] - acc_c[0], 9);
      check("mr_re_wb", done_wb[0], 1);
      check("mr_re_beats", nbeats, 4);

      // back-to-back, way changed after accept
      clear_mon();
      cfg_vld = 1; cfg_dirty = 0; cfg_tag = 24'h0; cfg_data = D2;
      @(negedge clk_i);
      evict_req_i = 1'b1;
      evict_index_i = 4'd6;
      victim_way_i = 2'd3;
      @(negedge clk_i);
      victim_way_i = 2'd0;
      wait_done(2);
      check("bb_acc_cnt", acc_c.size(), 2);
      check("bb_rd_way0", rd_w[0], 3);
      check("bb_done_way0", done_way[0], 3);
      check("bb_gap", acc_c[1] - done_c[0], 1);
      check("bb_rd_way1", rd_w[1], 0);
      check("bb_done_lat1", done_c[1] - acc_c[1], 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
